// File: rtl/const_cmp_pkg.sv
// Shared types and encodings for the constant sequence matcher.
package const_cmp_pkg;

  // Compare mode encodings as seen on cfg_mode.
  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_NE = 2'b01;
  localparam logic [1:0] MODE_GT = 2'b10;
  localparam logic [1:0] MODE_LT = 2'b11;

  typedef enum logic [1:0] {
    CMP_EQ = MODE_EQ,
    CMP_NE = MODE_NE,
    CMP_GT = MODE_GT,
    CMP_LT = MODE_LT
  } cmp_mode_e;

  // Detector states; the top keeps its state register as plain logic.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SEARCH = 2'b01;
  localparam logic [1:0] ST_DETECT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SEARCH = ST_SEARCH,
    DETECT = ST_DETECT
  } state_e;

endpackage

// File: rtl/const_cmp_core.sv
// Purely combinational compare of one sample against the pattern.
// EQ/NE honour the mask; GT/LT are full-width unsigned and ignore it.
module const_cmp_core
  import const_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic [1:0]       mode,
  output logic             hit
);

  cmp_mode_e mode_s;
  logic      eq_s;

  assign mode_s = cmp_mode_e'(mode);
  assign eq_s   = (((in_data ^ pattern) & mask) == '0);

  // Select the hit condition for the active mode.
  always_comb begin
    hit = 1'b0;
    case (mode_s)
      CMP_EQ:  hit = eq_s;
      CMP_NE:  hit = ~eq_s;
      CMP_GT:  hit = (in_data > pattern);
      CMP_LT:  hit = (in_data < pattern);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/const_seq_matcher.sv
// Registered, debounced pattern detector: a run of consecutive valid hits
// yields a one-cycle det pulse and a sticky flag.
// Optional feature macro: COMPARATOR_HIT_COUNT_EN adds the saturating
// hit_count output.
module const_seq_matcher
  import const_cmp_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               RUN_W         = 4,
  parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(5),
  parameter int               CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [1:0]       cfg_mode,
  input  logic [RUN_W-1:0] cfg_run,
  input  logic             clr_sticky,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             q,
  output logic             det,
  output logic             sticky,
  output logic             busy
`ifdef COMPARATOR_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  logic [WIDTH-1:0] pattern_r;
  logic [WIDTH-1:0] mask_r;
  logic [1:0]       mode_r;
  logic [RUN_W-1:0] run_r;
  logic [1:0]       state_r;
  logic [1:0]       state_n_s;
  logic [RUN_W-1:0] cnt_r;
  logic [RUN_W-1:0] cnt_n_s;
  logic [RUN_W-1:0] thr_s;
  logic [RUN_W:0]   cnt_inc_s;
  logic             q_r;
  logic             q_n_s;
  logic             det_r;
  logic             det_n_s;
  logic             sticky_r;
  logic             sticky_n_s;
  logic             hit_s;

  const_cmp_core #(.WIDTH(WIDTH)) u_core (
    .in_data (in_data),
    .pattern (pattern_r),
    .mask    (mask_r),
    .mode    (mode_r),
    .hit     (hit_s)
  );

  // A programmed run of 0 behaves like 1.
  assign thr_s     = (run_r == '0) ? RUN_W'(1) : run_r;
  assign cnt_inc_s = {1'b0, cnt_r} + {{RUN_W{1'b0}}, 1'b1};

  // Next-state, run counter, compare result and pulse/flag decisions.
  always_comb begin
    state_n_s  = state_r;
    cnt_n_s    = cnt_r;
    q_n_s      = q_r;
    det_n_s    = 1'b0;
    if (!en) begin
      state_n_s = ST_IDLE;
      cnt_n_s   = '0;
    end else if (cfg_load) begin
      // The accompanying sample still sees the old configuration.
      state_n_s = ST_SEARCH;
      cnt_n_s   = '0;
      if (in_valid) begin
        q_n_s = hit_s;
      end else begin
        q_n_s = q_r;
      end
    end else if (state_r == ST_IDLE) begin
      // Waking up: the sample updates q but does not start a run.
      state_n_s = ST_SEARCH;
      if (in_valid) begin
        q_n_s = hit_s;
      end else begin
        q_n_s = q_r;
      end
    end else if (in_valid) begin
      q_n_s = hit_s;
      case (state_r)
        ST_SEARCH: begin
          if (!hit_s) begin
            cnt_n_s = '0;
          end else if (cnt_inc_s >= {1'b0, thr_s}) begin
            cnt_n_s   = thr_s;
            state_n_s = ST_DETECT;
            det_n_s   = 1'b1;
          end else begin
            cnt_n_s = cnt_inc_s[RUN_W-1:0];
          end
        end
        ST_DETECT: begin
          if (hit_s) begin
            cnt_n_s = cnt_r;
          end else begin
            cnt_n_s   = '0;
            state_n_s = ST_SEARCH;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          cnt_n_s   = '0;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
    // Setting (new or visible det) takes priority over a clear request.
    if (det_n_s || det_r) begin
      sticky_n_s = 1'b1;
    end else if (clr_sticky) begin
      sticky_n_s = 1'b0;
    end else begin
      sticky_n_s = sticky_r;
    end
  end

  // Configuration registers, loaded regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= RESET_PATTERN;
      mask_r    <= '1;
      mode_r    <= MODE_EQ;
      run_r     <= RUN_W'(1);
    end else if (cfg_load) begin
      pattern_r <= cfg_pattern;
      mask_r    <= cfg_mask;
      mode_r    <= cfg_mode;
      run_r     <= cfg_run;
    end else begin
      pattern_r <= pattern_r;
      mask_r    <= mask_r;
      mode_r    <= mode_r;
      run_r     <= run_r;
    end
  end

  // Detector state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      q_r      <= 1'b0;
      det_r    <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      cnt_r    <= cnt_n_s;
      q_r      <= q_n_s;
      det_r    <= det_n_s;
      sticky_r <= sticky_n_s;
    end
  end

  assign q      = q_r;
  assign det    = det_r;
  assign sticky = sticky_r;
  assign busy   = (state_r != ST_IDLE);

`ifdef COMPARATOR_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_cnt_r;

  // Saturating count of valid hits while enabled; cleared by a config load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r <= '0;
    end else if (cfg_load) begin
      hit_cnt_r <= '0;
    end else if (en && in_valid && hit_s && (hit_cnt_r != '1)) begin
      hit_cnt_r <= hit_cnt_r + CNT_W'(1);
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  assign hit_count = hit_cnt_r;
`endif

endmodule

// File: tb/tb_const_seq_matcher.sv
// Self-checking bench for const_seq_matcher: directed vector table,
// hand-written reset/counter sequences, and a randomized run against a
// streak-based reference model.
module tb_const_seq_matcher;

  localparam int W  = 4;
  localparam int RW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          cfg_load;
  logic [W-1:0]  cfg_pattern;
  logic [W-1:0]  cfg_mask;
  logic [1:0]    cfg_mode;
  logic [RW-1:0] cfg_run;
  logic          clr_sticky;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          q, det, sticky, busy;
`ifdef COMPARATOR_HIT_COUNT_EN
  logic [CW-1:0] hit_count;
`endif

  always #5 clk = ~clk;

  const_seq_matcher #(
    .WIDTH(W), .RUN_W(RW), .RESET_PATTERN(4'h5), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
    .cfg_run(cfg_run), .clr_sticky(clr_sticky), .in_valid(in_valid),
    .in_data(in_data), .q(q), .det(det), .sticky(sticky), .busy(busy)
`ifdef COMPARATOR_HIT_COUNT_EN
    , .hit_count(hit_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vector table.
  typedef struct {
    logic       en, ld;
    logic [3:0] pat, msk;
    logic [1:0] mode;
    logic [3:0] run;
    logic       clr, v;
    logic [3:0] d;
    logic       eq, edet, est, ebusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic l, input logic [3:0] p,
                              input logic [3:0] m, input logic [1:0] md, input logic [3:0] r,
                              input logic c, input logic v, input logic [3:0] d,
                              input logic eq, input logic ed, input logic es, input logic eb);
    vec_t t;
    t.en = e; t.ld = l; t.pat = p; t.msk = m; t.mode = md; t.run = r;
    t.clr = c; t.v = v; t.d = d; t.eq = eq; t.edet = ed; t.est = es; t.ebusy = eb;
    return t;
  endfunction

  // Reference model: counts consecutive hits as a plain streak.
  logic [3:0] m_pat, m_msk, m_run;
  logic [1:0] m_mode;
  bit         m_prev_en, m_prev_det, m_q, m_sticky, m_det;
  int         m_streak, m_hits;

  function automatic bit ref_hit(input logic [3:0] d, input logic [3:0] p,
                                 input logic [3:0] m, input logic [1:0] md);
    int di = int'(d);
    int pi = int'(p);
    case (md)
      2'd0:    return (d & m) == (p & m);
      2'd1:    return (d & m) != (p & m);
      2'd2:    return di > pi;
      default: return di < pi;
    endcase
  endfunction

  task automatic model_reset();
    m_pat = 4'h5; m_msk = 4'hF; m_mode = 2'd0; m_run = 4'd1;
    m_prev_en = 1'b0; m_prev_det = 1'b0; m_q = 1'b0; m_sticky = 1'b0;
    m_det = 1'b0; m_streak = 0; m_hits = 0;
  endtask

  task automatic model_step();
    bit h;
    int thr;
    h = ref_hit(in_data, m_pat, m_msk, m_mode);
    thr = (m_run == 4'd0) ? 1 : int'(m_run);
    m_det = 1'b0;
    if (!en) begin
      m_streak = 0;
    end else if (cfg_load) begin
      if (in_valid) m_q = h;
      m_streak = 0;
    end else if (in_valid) begin
      m_q = h;
      if (m_prev_en) begin
        if (h) begin
          m_streak++;
          if (m_streak == thr) m_det = 1'b1;
        end else begin
          m_streak = 0;
        end
      end
    end
    if (m_det || m_prev_det) m_sticky = 1'b1;
    else if (clr_sticky) m_sticky = 1'b0;
    if (cfg_load) m_hits = 0;
    else if (en && in_valid && h && m_hits < 3) m_hits++;
    if (cfg_load) begin
      m_pat = cfg_pattern; m_msk = cfg_mask; m_mode = cfg_mode; m_run = cfg_run;
    end
    m_prev_en  = en;
    m_prev_det = m_det;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'h0; cfg_mask = 4'hF;
    cfg_mode = 2'd0; cfg_run = 4'd1; clr_sticky = 1'b0; in_valid = 1'b0; in_data = 4'h0;

    //           en ld pat   msk   md    run   clr v  d      q  det st busy
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd1, 0, 0, 4'h0, 0, 0, 0, 1)); // 0 wake
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd1, 0, 1, 4'h5, 1, 1, 1, 1)); // 1 default hit
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd1, 0, 1, 4'h4, 0, 0, 1, 1)); // 2 miss
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd1, 1, 0, 4'h0, 0, 0, 0, 1)); // 3 clr
    vecs.push_back(mk(1, 1, 4'hA, 4'hF, 2'd0, 4'd3, 0, 0, 4'h0, 0, 0, 0, 1)); // 4 run=3
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hA, 1, 0, 0, 1)); // 5
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hA, 1, 0, 0, 1)); // 6
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h7, 0, 0, 0, 1)); // 7 break
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hA, 1, 0, 0, 1)); // 8
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hA, 1, 0, 0, 1)); // 9
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hA, 1, 1, 1, 1)); // 10 det
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 0, 4'hA, 1, 0, 1, 1)); // 11-15 gap
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hA, 1, 0, 1, 1)); // 16 no re-det
    vecs.push_back(mk(1, 1, 4'h4, 4'hC, 2'd0, 4'd1, 1, 0, 4'h0, 1, 0, 0, 1)); // 17 mask
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 1, 1, 4'h7, 1, 1, 1, 1)); // 18 masked hit+clr
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 1, 0, 4'h0, 1, 0, 1, 1)); // 19 clr vs det
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 1, 0, 4'h0, 1, 0, 0, 1)); // 20 clr alone
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h8, 0, 0, 0, 1)); // 21 masked miss
    vecs.push_back(mk(1, 1, 4'h9, 4'hF, 2'd2, 4'd1, 0, 0, 4'h0, 0, 0, 0, 1)); // 22 GT 9
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h9, 0, 0, 0, 1)); // 23 9 !> 9
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hA, 1, 1, 1, 1)); // 24 A > 9
    vecs.push_back(mk(1, 1, 4'h9, 4'hF, 2'd3, 4'd1, 0, 0, 4'h0, 1, 0, 1, 1)); // 25 LT 9
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h0, 1, 1, 1, 1)); // 26 0 < 9
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'hF, 0, 0, 1, 1)); // 27 F miss
    vecs.push_back(mk(0, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h0, 0, 0, 1, 0)); // 28 en low
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h0, 1, 0, 1, 1)); // 29 wake sample
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h0, 1, 1, 1, 1)); // 30
    vecs.push_back(mk(1, 1, 4'h0, 4'hF, 2'd0, 4'd1, 0, 1, 4'h0, 1, 0, 1, 1)); // 31 ld+old cfg
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h0, 1, 1, 1, 1)); // 32 new EQ 0
    vecs.push_back(mk(1, 1, 4'h3, 4'hF, 2'd1, 4'd1, 0, 0, 4'h0, 1, 0, 1, 1)); // 33 NE 3
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h3, 0, 0, 1, 1)); // 34
    vecs.push_back(mk(1, 0, 4'h0, 4'hF, 2'd0, 4'd0, 0, 1, 4'h4, 1, 1, 1, 1)); // 35

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", q, 0);
    check("reset_det", det, 0);
    check("reset_sticky", sticky, 0);
    check("reset_busy", busy, 0);
`ifdef COMPARATOR_HIT_COUNT_EN
    check("reset_hit_count", hit_count, 0);
`endif
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en; cfg_load = vecs[i].ld; cfg_pattern = vecs[i].pat;
      cfg_mask = vecs[i].msk; cfg_mode = vecs[i].mode; cfg_run = vecs[i].run;
      clr_sticky = vecs[i].clr; in_valid = vecs[i].v; in_data = vecs[i].d;
      step();
      check($sformatf("vec%0d_q", i), q, vecs[i].eq);
      check($sformatf("vec%0d_det", i), det, vecs[i].edet);
      check($sformatf("vec%0d_sticky", i), sticky, vecs[i].est);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
    end

    // Asynchronous reset in the middle of a cycle.
    cfg_load = 1'b0; clr_sticky = 1'b0; in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_q", q, 0);
    check("midrst_det", det, 0);
    check("midrst_sticky", sticky, 0);
    check("midrst_busy", busy, 0);
    step();
    rst_n = 1'b1; en = 1'b1;
    step();
    in_valid = 1'b1; in_data = 4'h5;
    step();
    check("after_rst_pattern5_q", q, 1);
    check("after_rst_pattern5_det", det, 1);
    in_valid = 1'b0;

`ifdef COMPARATOR_HIT_COUNT_EN
    // Saturation of the hit counter and clearing on config load.
    cfg_load = 1'b1; cfg_pattern = 4'h5; cfg_mask = 4'hF; cfg_mode = 2'd0; cfg_run = 4'd1;
    step();
    check("hitcnt_after_load", hit_count, 0);
    cfg_load = 1'b0; in_valid = 1'b1; in_data = 4'h5;
    repeat (5) step();
    check("hitcnt_saturated", hit_count, 3);
    in_valid = 1'b0; cfg_load = 1'b1;
    step();
    check("hitcnt_cleared", hit_count, 0);
    cfg_load = 1'b0;
`endif

    // Randomized run against the reference model.
    rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; clr_sticky = 1'b0;
    step();
    model_reset();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      en          = ($urandom_range(0, 99) < 95);
      cfg_load    = ($urandom_range(0, 99) < 3);
      cfg_pattern = 4'($urandom);
      cfg_mask    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      cfg_mode    = 2'($urandom);
      cfg_run     = 4'($urandom_range(0, 3));
      clr_sticky  = ($urandom_range(0, 99) < 10);
      in_valid    = ($urandom_range(0, 99) < 70);
      in_data     = ($urandom_range(0, 1) == 0) ? m_pat : 4'($urandom);
      model_step();
      step();
      check("rand_q", q, m_q);
      check("rand_det", det, m_det);
      check("rand_sticky", sticky, m_sticky);
      check("rand_busy", busy, m_prev_en);
`ifdef COMPARATOR_HIT_COUNT_EN
      check("rand_hit_count", hit_count, m_hits);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
